// File: rtl/stage_rle_writer.sv
// RLE stage image decoder: expands ROM runs into raster-order stageRAM writes.
// Optional STAGE_WRITER_VBLANK_EN holds RUN writes while vid_active is high.
module stage_rle_writer #(
  parameter int unsigned STAGE_W = 208,
  parameter int unsigned STAGE_H = 200,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned ROM_AW  = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] stage_base,
  input  logic              vid_active,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [1:0]        data_In,
  output logic              we,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NPIX = STAGE_W * STAGE_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [5:0]        run_q, run_d;
  logic [1:0]        color_q, color_d;
  logic              wr_ok;

`ifdef STAGE_WRITER_VBLANK_EN
  // Writes only land outside the visible frame to avoid tearing.
  assign wr_ok = ~vid_active;
`else
  logic unused_vid;
  assign unused_vid = vid_active;
  assign wr_ok      = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      pix_q      <= '0;
      run_q      <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pix_q      <= pix_d;
      run_q      <= run_d;
      color_q    <= color_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    pix_d      = pix_q;
    run_d      = run_q;
    color_d    = color_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d = stage_base;
          pix_d      = '0;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        color_d    = rom_data[7:6];
        run_d      = rom_data[5:0];
        rom_addr_d = rom_addr_q + 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (wr_ok) begin
          pix_d = pix_q + 1'b1;
          // Last pixel ends the load even mid-run.
          if (pix_q == LAST) begin
            state_d = DONE;
          end else if (run_q == 6'd0) begin
            state_d = FETCH;
          end else begin
            run_d = run_q - 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr      = rom_addr_q;
  assign write_address = pix_q;
  assign data_In       = color_q;
  assign we            = (state_q == RUN) && wr_ok;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_stage_rle_writer.sv
// Bench for stage_rle_writer: expands ROM words into an expected cycle trace
// and compares every cycle of each load against it.
module tb_stage_rle_writer;

  localparam int SW   = 208;
  localparam int SH   = 200;
  localparam int NPIX = SW * SH;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [11:0] stage_base;
  logic        vid_active;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] write_address;
  logic [1:0]  data_In;
  logic        we;
  logic        busy;
  logic        done;

  logic [7:0] rom [0:4095];

  int checks = 0;
  int errors = 0;
  int g_cycles, g_writes, g_last, g_words, g_first_we;

  stage_rle_writer #(
    .STAGE_W(SW), .STAGE_H(SH), .ADDR_W(16), .ROM_AW(12)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .stage_base(stage_base), .vid_active(vid_active),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .write_address(write_address), .data_In(data_In),
    .we(we), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " rom_addr"}, int'(rom_addr), 0);
    chk({tag, " wr_addr"}, int'(write_address), 0);
    chk({tag, " data_In"}, int'(data_In), 0);
    chk({tag, " we"}, int'(we), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
  endtask

  // Trace codes: -1 fetch cycle, -2 load cycle, >=0 write of that color.
  task automatic run_load(input int base, input int limit, input int mid_c);
    int tr[$];
    int pixels, w, len, col, ncyc, widx, idx, e;
    logic [7:0] word;
    pixels = 0;
    w = 0;
    while (pixels < NPIX) begin
      word = rom[(base + w) % 4096];
      len  = int'(word[5:0]) + 1;
      col  = int'(word[7:6]);
      tr.push_back(-1);
      tr.push_back(-2);
      for (int j = 0; j < len && pixels < NPIX; j++) begin
        tr.push_back(col);
        pixels++;
      end
      w++;
    end
    g_words = w;
    g_first_we = -1;
    stage_base = 12'(base);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    ncyc = (limit > 0) ? limit : tr.size();
    widx = 0;
    idx = 0;
    g_last = -1;
    for (int c = 1; c <= ncyc; c++) begin
      e = tr[c-1];
      chk("busy", int'(busy), 1);
      chk("done", int'(done), 0);
      chk("we", int'(we), (e >= 0) ? 1 : 0);
      if (e == -1) begin
        chk("rom_addr", int'(rom_addr), (base + widx) % 4096);
        widx++;
      end
      if (e >= 0) begin
        if (g_first_we < 0) g_first_we = c;
        chk("wr_addr", int'(write_address), idx);
        chk("data_In", int'(data_In), e);
        g_last = int'(write_address);
        idx++;
      end
      if (c == mid_c) begin
        stage_base = 12'h800;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    g_writes = idx;
    g_cycles = ncyc + 1;
    if (limit == 0) begin
      chk("done pulse", int'(done), 1);
      chk("busy at done", int'(busy), 1);
      chk("we at done", int'(we), 0);
      @(negedge Clk);
      chk("done fall", int'(done), 0);
      chk("busy fall", int'(busy), 0);
      chk("we after", int'(we), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0] = 8'hC3;
    rom[1] = 8'h00;
    for (int i = 200; i < 1000; i++) rom[i] = 8'h3F;
    for (int i = 0; i < 649; i++) rom[1000 + i] = {2'(i), 6'h3F};
    rom[1649] = 8'h75;
    rom[1650] = 8'hD3;

    Reset = 1'b1;
    start = 1'b0;
    stage_base = '0;
    vid_active = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_idle_zero("reset");
    Reset = 1'b0;
    @(negedge Clk);

    // Single run 0xC3: four writes of color 3, then next fetch at 1.
    run_load(0, 8, 0);
    chk("single first we cycle", g_first_we, 3);
    chk("single write count", g_writes, 4);
    chk("single last addr", g_last, 3);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    // Reset while writing pixel 100.
    run_load(200, 104, 0);
    chk("pre-reset we", int'(we), 1);
    chk("pre-reset addr", int'(write_address), 100);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk_idle_zero("mid reset");
    @(negedge Clk);
    run_load(200, 70, 0);
    chk("restart last addr", g_last, 65);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Full stage whose final word overruns by 10 px, with an ignored start.
    run_load(1000, 0, 500);
    chk("full word count", g_words, 651);
    chk("full done cycle", g_cycles, 2 * 651 + NPIX + 1);
    chk("full write count", g_writes, 41600);
    chk("full last addr", g_last, 41599);
    repeat (3) begin
      @(negedge Clk);
      chk("idle we", int'(we), 0);
      chk("idle busy", int'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
